// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: ARM condition codes,
// flag bit positions and the branch-shadow state encoding.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [15:0] SQUASH_CNT_MAX = 16'hFFFF;

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

endpackage

// File: rtl/cond_unit_if.sv
// Decoder-to-datapath control bundle passing through the condition unit.
// squash_cnt exists only when COND_SQUASH_CNT_EN is defined.
interface cond_unit_if;

    logic       in_valid;
    logic       stall;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic [1:0] flag_w;

    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       squash;
    logic [3:0] flags;
`ifdef COND_SQUASH_CNT_EN
    logic [15:0] squash_cnt;
`endif

    modport master (
        output in_valid, stall, cond, alu_flags, pcs, reg_w, mem_w, no_write, flag_w,
        input  pc_src, reg_write, mem_write, squash, flags
`ifdef COND_SQUASH_CNT_EN
        , input squash_cnt
`endif
    );

    modport slave (
        input  in_valid, stall, cond, alu_flags, pcs, reg_w, mem_w, no_write, flag_w,
        output pc_src, reg_write, mem_write, squash, flags
`ifdef COND_SQUASH_CNT_EN
        , output squash_cnt
`endif
    );

endinterface

// File: rtl/cond_check.sv
// Pure combinational ARM condition evaluator over the {N,Z,C,V} flag register.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_true
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = z;
            COND_NE: cond_true = ~z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = ~c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = ~n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = ~v;
            COND_HI: cond_true = c & ~z;
            COND_LS: cond_true = ~c | z;
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = ~z & (n == v);
            COND_LE: cond_true = z | (n != v);
            COND_AL: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution gate: qualifies decoder write enables against the
// registered flags and annuls the single slot after a taken branch.
// Optional cond-fail counter enabled by COND_SQUASH_CNT_EN.
module cond_unit
    import cond_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    cond_unit_if.slave  bus
);

    state_t     state_q;
    logic [3:0] flags_q;
    logic [3:0] flags_eff;
    logic       in_run;
    logic       cond_true;
    logic       active;
    logic       cond_ex;

    // While reset is asserted the gating already sees the post-reset state.
    assign in_run    = ~rst_n | (state_q == RUN);
    assign flags_eff = rst_n ? flags_q : 4'b0000;

    cond_check u_check (
        .cond      (bus.cond),
        .flags     (flags_eff),
        .cond_true (cond_true)
    );

    assign active  = bus.in_valid & ~bus.stall;
    assign cond_ex = active & in_run & cond_true;

    assign bus.pc_src    = bus.pcs & cond_ex;
    assign bus.mem_write = bus.mem_w & cond_ex;
    assign bus.reg_write = bus.reg_w & ~bus.no_write & cond_ex;
    assign bus.squash    = active & ~cond_ex;
    assign bus.flags     = flags_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            flags_q <= 4'b0000;
        end else begin
            case (state_q)
                RUN:     if (bus.pc_src) state_q <= SHADOW;
                SHADOW:  if (active)     state_q <= RUN;
                default: state_q <= RUN;
            endcase
            if (cond_ex) begin
                if (bus.flag_w[1]) flags_q[3:2] <= bus.alu_flags[3:2];
                if (bus.flag_w[0]) flags_q[1:0] <= bus.alu_flags[1:0];
            end
        end
    end

`ifdef COND_SQUASH_CNT_EN
    logic [15:0] squash_cnt_q;

    // Only genuine condition failures count; shadow annulments do not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            squash_cnt_q <= '0;
        end else if (active && (state_q == RUN) && !cond_true &&
                     (squash_cnt_q != SQUASH_CNT_MAX)) begin
            squash_cnt_q <= squash_cnt_q + 16'd1;
        end
    end

    assign bus.squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed vectors push hand-computed
// expectations; a monitor on the falling edge pops and compares.
module tb_cond_unit;
    import cond_pkg::*;

    typedef struct {
        logic        pc_src;
        logic        reg_write;
        logic        mem_write;
        logic        squash;
        logic [3:0]  flags;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];

    cond_unit_if bus ();

    cond_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_checks++;
        if (act !== want) $display("FAIL %s: got %0h want %0h", name, act, want);
        else              n_pass++;
    endtask

    // Monitor: outputs are presented every driven cycle; sample mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("pc_src",    {15'd0, bus.pc_src},    {15'd0, e.pc_src});
                check("reg_write", {15'd0, bus.reg_write}, {15'd0, e.reg_write});
                check("mem_write", {15'd0, bus.mem_write}, {15'd0, e.mem_write});
                check("squash",    {15'd0, bus.squash},    {15'd0, e.squash});
                check("flags",     {12'd0, bus.flags},     {12'd0, e.flags});
`ifdef COND_SQUASH_CNT_EN
                check("squash_cnt", bus.squash_cnt, e.cnt);
`endif
            end
        end
    end

    task automatic drive(input logic r, iv, st, input logic [3:0] c, af,
                         input logic p, rw, mw, nw, input logic [1:0] fw,
                         input logic e_pc, e_rw, e_mw, e_sq,
                         input logic [3:0] e_fl, input logic [15:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.in_valid  = iv;
        bus.stall     = st;
        bus.cond      = c;
        bus.alu_flags = af;
        bus.pcs       = p;
        bus.reg_w     = rw;
        bus.mem_w     = mw;
        bus.no_write  = nw;
        bus.flag_w    = fw;
        e.pc_src    = e_pc;
        e.reg_write = e_rw;
        e.mem_write = e_mw;
        e.squash    = e_sq;
        e.flags     = e_fl;
        e.cnt       = e_cnt;
        sb_q.push_back(e);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.stall     = 1'b0;
        bus.cond      = COND_AL;
        bus.alu_flags = 4'b0000;
        bus.pcs       = 1'b0;
        bus.reg_w     = 1'b0;
        bus.mem_w     = 1'b0;
        bus.no_write  = 1'b0;
        bus.flag_w    = 2'b00;

        //    rst iv st cond     alu      pcs rw mw nw fw     | pc rw mw sq flags    cnt
        // Reset state, then outputs during reset; reset beats flag write.
        drive(0, 0, 0, COND_AL, 4'b0000, 0, 0, 0, 0, 2'b00,  0, 0, 0, 0, 4'b0000, 16'd0);
        drive(0, 1, 0, COND_AL, 4'b1111, 0, 1, 0, 0, 2'b11,  0, 1, 0, 0, 4'b0000, 16'd0);
        // AL executes and writes all flags.
        drive(1, 1, 0, COND_AL, 4'b0100, 0, 1, 0, 0, 2'b11,  0, 1, 0, 0, 4'b0000, 16'd0);
        // Z=1: NE fails, counted, flags held.
        drive(1, 1, 0, COND_NE, 4'b1111, 0, 0, 1, 0, 2'b11,  0, 0, 0, 1, 4'b0100, 16'd0);
        drive(1, 0, 0, COND_AL, 4'b0000, 0, 0, 0, 0, 2'b00,  0, 0, 0, 0, 4'b0100, 16'd1);
        // EQ true; no_write blocks reg_write; only N,Z written.
        drive(1, 1, 0, COND_EQ, 4'b1000, 0, 1, 1, 1, 2'b10,  0, 0, 1, 0, 4'b0100, 16'd1);
        // Stall masks everything.
        drive(1, 1, 1, COND_AL, 4'b0001, 1, 1, 1, 0, 2'b11,  0, 0, 0, 0, 4'b1000, 16'd1);
        // MI true (N=1); only C,V written -> 1011.
        drive(1, 1, 0, COND_MI, 4'b0011, 0, 1, 0, 0, 2'b01,  0, 1, 0, 0, 4'b1000, 16'd1);
        // N=1,V=1: LT fails; HI true (C=1,Z=0); NV always fails.
        drive(1, 1, 0, COND_LT, 4'b0000, 0, 1, 0, 0, 2'b11,  0, 0, 0, 1, 4'b1011, 16'd1);
        drive(1, 1, 0, COND_HI, 4'b0000, 0, 0, 1, 0, 2'b00,  0, 0, 1, 0, 4'b1011, 16'd2);
        drive(1, 1, 0, COND_NV, 4'b0000, 0, 1, 0, 0, 2'b00,  0, 0, 0, 1, 4'b1011, 16'd2);
        // Taken branch, annulled shadow slot (not counted), then normal execution.
        drive(1, 1, 0, COND_AL, 4'b0000, 1, 0, 0, 0, 2'b00,  1, 0, 0, 0, 4'b1011, 16'd3);
        drive(1, 1, 0, COND_AL, 4'b0000, 0, 1, 0, 0, 2'b11,  0, 0, 0, 1, 4'b1011, 16'd3);
        drive(1, 1, 0, COND_AL, 4'b0000, 0, 1, 0, 0, 2'b00,  0, 1, 0, 0, 4'b1011, 16'd3);
        // GE branch; shadow survives 3 stalls and 2 bubbles; first real slot annulled.
        drive(1, 1, 0, COND_GE, 4'b0000, 1, 0, 0, 0, 2'b00,  1, 0, 0, 0, 4'b1011, 16'd3);
        for (int i = 0; i < 3; i++)
            drive(1, 1, 1, COND_AL, 4'b0000, 1, 1, 1, 0, 2'b11,  0, 0, 0, 0, 4'b1011, 16'd3);
        for (int i = 0; i < 2; i++)
            drive(1, 0, 0, COND_AL, 4'b0000, 1, 1, 1, 0, 2'b11,  0, 0, 0, 0, 4'b1011, 16'd3);
        drive(1, 1, 0, COND_AL, 4'b0000, 0, 1, 1, 0, 2'b11,  0, 0, 0, 1, 4'b1011, 16'd3);
        drive(1, 1, 0, COND_AL, 4'b0000, 0, 0, 1, 0, 2'b00,  0, 0, 1, 0, 4'b1011, 16'd3);
`ifdef COND_SQUASH_CNT_EN
        @(negedge clk);
        #1 force u_dut.squash_cnt_q = 16'hFFFE;
        #1 release u_dut.squash_cnt_q;
`endif
        // Counter saturation at 16'hFFFF.
        drive(1, 1, 0, COND_LT, 4'b0000, 0, 0, 0, 0, 2'b00,  0, 0, 0, 1, 4'b1011, 16'hFFFE);
        drive(1, 1, 0, COND_LT, 4'b0000, 0, 0, 0, 0, 2'b00,  0, 0, 0, 1, 4'b1011, 16'hFFFF);
        // Branch into SHADOW, reset there, next instruction executes.
        drive(1, 1, 0, COND_AL, 4'b0000, 1, 0, 0, 0, 2'b00,  1, 0, 0, 0, 4'b1011, 16'hFFFF);
        drive(0, 0, 0, COND_AL, 4'b0000, 0, 0, 0, 0, 2'b00,  0, 0, 0, 0, 4'b1011, 16'hFFFF);
        drive(1, 1, 0, COND_AL, 4'b0000, 0, 1, 0, 0, 2'b00,  0, 1, 0, 0, 4'b0000, 16'd0);
        // Z=0 after reset: EQ fails.
        drive(1, 1, 0, COND_EQ, 4'b0000, 0, 0, 1, 0, 2'b00,  0, 0, 0, 1, 4'b0000, 16'd0);
        drive(1, 0, 0, COND_AL, 4'b0000, 0, 0, 0, 0, 2'b00,  0, 0, 0, 0, 4'b0000, 16'd1);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL drain: got %0d pending want 0", sb_q.size());
        else                  n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
